// File: rtl/data_parallelizer_pkg.sv
// Shared definitions for the parallelizer / serializer width converters.
//   RATIO_MIN / RATIO_MAX : legal range of beats per wide word
//   lane_cnt_width()      : width of a lane counter for a given ratio
//   keep_mask()           : mask with the n lowest bits set (n <= RATIO_MAX)
package data_parallelizer_pkg;

    localparam int unsigned RATIO_MIN = 2;
    localparam int unsigned RATIO_MAX = 16;

    function automatic int unsigned lane_cnt_width(input int unsigned ratio);
        return (ratio <= 2) ? 1 : $clog2(ratio);
    endfunction

    function automatic logic [RATIO_MAX-1:0] keep_mask(input int unsigned n);
        logic [RATIO_MAX-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < RATIO_MAX; i++) begin
            m[i] = (i < n);
        end
        return m;
    endfunction

endpackage

// File: rtl/data_parallelizer_out_slice.sv
// Output register of the parallelizer: holds one packed word and its keep
// mask under valid/ready handshake.
//   clk, rst         : clock, synchronous active-high reset
//   load             : capture load_data/load_keep, assert valid next cycle
//   load_data/keep   : word and lane mask to capture
//   ready            : downstream accepts the held word
//   valid/data/keep  : registered output word
// A load takes priority over a drain, so a word leaving and a new word
// arriving in the same cycle keeps valid high with no bubble.
module data_parallelizer_out_slice #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned KEEP_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic [KEEP_W-1:0] load_keep,
    input  logic              ready,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [KEEP_W-1:0] keep
);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
            keep  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
            keep  <= load_keep;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/data_parallelizer_n.sv
// Packs RATIO consecutive DIN_WIDTH-bit beats into one RATIO*DIN_WIDTH-bit
// word (first beat in lane 0 / LSBs) with a keep mask and early close via iLAST.
//   CLK, RESET     : clock, synchronous active-high reset (dominant)
//   iVALID/oREADY  : input beat handshake, DIN beat data, iLAST closes word
//   oVALID/iREADY  : output word handshake, DOUT packed word, oKEEP lane mask
// Optional macro DATA_PARALLELIZER_TIMEOUT_FLUSH_EN: a partial word idle for
// TIMEOUT_CYCLES cycles is flushed as if iLAST had arrived.
module data_parallelizer_n
    import data_parallelizer_pkg::*;
#(
    parameter int unsigned DIN_WIDTH      = 32,
    parameter int unsigned RATIO          = 2,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       iVALID,
    output logic                       oREADY,
    input  logic [DIN_WIDTH-1:0]       DIN,
    input  logic                       iLAST,
    output logic                       oVALID,
    input  logic                       iREADY,
    output logic [RATIO*DIN_WIDTH-1:0] DOUT,
    output logic [RATIO-1:0]           oKEEP
);

    localparam int unsigned CW = lane_cnt_width(RATIO);
    localparam int unsigned OW = RATIO * DIN_WIDTH;

    if (RATIO < RATIO_MIN || RATIO > RATIO_MAX) begin : g_ratio_chk
        $error("data_parallelizer_n: RATIO out of range");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_chk
        $error("data_parallelizer_n: TIMEOUT_CYCLES must be at least 1");
    end

    logic [CW-1:0]        cnt;
    logic [DIN_WIDTH-1:0] acc [0:RATIO-2];
    logic                 out_valid;
    logic                 free;
    logic                 in_xfer;
    logic                 complete;
    logic                 flush;
    logic                 load;
    logic [OW-1:0]        load_data;
    logic [RATIO-1:0]     load_keep;

    // Output register is free when empty or draining this cycle.
    assign free     = !out_valid || iREADY;
    assign oREADY   = !RESET && free;
    assign in_xfer  = iVALID && oREADY;
    assign complete = in_xfer && ((cnt == CW'(RATIO - 1)) || iLAST);
    assign load     = complete || flush;
    assign oVALID   = out_valid;

    // Lanes below cnt come from the accumulator; lane cnt takes the current
    // beat unless this is a timeout flush; everything above stays zero.
    always_comb begin
        load_data = '0;
        for (int unsigned k = 0; k < RATIO - 1; k++) begin
            if (k < 32'(cnt)) begin
                load_data[k*DIN_WIDTH +: DIN_WIDTH] = acc[k];
            end
        end
        if (!flush) begin
            load_data[32'(cnt)*DIN_WIDTH +: DIN_WIDTH] = DIN;
        end
        load_keep = RATIO'(keep_mask(flush ? 32'(cnt) : 32'(cnt) + 1));
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt <= '0;
            for (int unsigned i = 0; i < RATIO - 1; i++) begin
                acc[i] <= '0;
            end
        end else if (load) begin
            cnt <= '0;
        end else if (in_xfer) begin
            acc[cnt] <= DIN;
            cnt      <= cnt + 1'b1;
        end
    end

`ifdef DATA_PARALLELIZER_TIMEOUT_FLUSH_EN
    localparam int unsigned IW = $clog2(TIMEOUT_CYCLES + 1);

    logic [IW-1:0] idle_cnt;

    // Saturates at the limit so a stalled flush keeps waiting for the
    // output register instead of wrapping.
    assign flush = (32'(idle_cnt) >= TIMEOUT_CYCLES) && (cnt != '0) && free && !in_xfer;

    always_ff @(posedge CLK) begin
        if (RESET || in_xfer || flush) begin
            idle_cnt <= '0;
        end else if ((cnt != '0) && (32'(idle_cnt) < TIMEOUT_CYCLES)) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end
`else
    assign flush = 1'b0;
`endif

    data_parallelizer_out_slice #(
        .DATA_W (OW),
        .KEEP_W (RATIO)
    ) u_out_slice (
        .clk       (CLK),
        .rst       (RESET),
        .load      (load),
        .load_data (load_data),
        .load_keep (load_keep),
        .ready     (iREADY),
        .valid     (out_valid),
        .data      (DOUT),
        .keep      (oKEEP)
    );

endmodule
